// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - 3-requester round-robin arbiter writing a 4x8 register bank.
// Define REGBANK_ARB_STATS_EN to add the saturating wr_count output.
module regbank_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [5:0]  waddr,
  input  logic [23:0] wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  input  logic [1:0]  raddr,
  output logic [7:0]  rdata,
  output logic        busy
`ifdef REGBANK_ARB_STATS_EN
  ,
  output logic [7:0]  wr_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      winner_q, winner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0][7:0] bank_q, bank_d;

  logic [1:0] pick;
  logic [2:0] win_oh;
  logic       win_req;
  logic [1:0] win_addr;
  logic [7:0] win_data;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // ptr_q names the requester with highest priority; the other two follow cyclically.
  always_comb begin
    pick = ptr_q;
    case (ptr_q)
      2'd1:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    win_oh   = 3'b001;
    win_addr = waddr[1:0];
    win_data = wdata[7:0];
    case (winner_q)
      2'd1: begin
        win_oh   = 3'b010;
        win_addr = waddr[3:2];
        win_data = wdata[15:8];
      end
      2'd2: begin
        win_oh   = 3'b100;
        win_addr = waddr[5:4];
        win_data = wdata[23:16];
      end
      default: ;
    endcase
    win_req = |(req & win_oh);
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    bank_d   = bank_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          winner_d = pick;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A dropped request aborts without touching the bank or the priority pointer.
        if (win_req) begin
          bank_d[win_addr] = win_data;
          ptr_d            = inc3(winner_q);
          state_d          = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      winner_q <= 2'd0;
      ptr_q    <= 2'd0;
      bank_q   <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      bank_q   <= bank_d;
    end
  end

  assign gnt   = (state_q == GRANT) ? win_oh : 3'b000;
  assign ack   = (state_q == WRITE) ? win_oh : 3'b000;
  assign busy  = (state_q != IDLE);
  assign rdata = bank_q[raddr];

`ifdef REGBANK_ARB_STATS_EN
  logic [7:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if ((state_q == GRANT) && win_req && (wr_count_q != 8'hFF)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_q <= 8'h00;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - self-checking bench for regbank_arbiter.
// Directed table, corner sequences, and randomized traffic against a transaction model.
module tb_regbank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  waddr;
  logic [23:0] wdata;
  logic [1:0]  raddr;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
`ifdef REGBANK_ARB_STATS_EN
  logic [7:0]  wr_count;
`endif

  regbank_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .waddr (waddr),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .raddr (raddr),
    .rdata (rdata),
    .busy  (busy)
`ifdef REGBANK_ARB_STATS_EN
    ,
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Transaction-level model: a request is an event that spans grant then ack.
  int         m_phase;  // 0 none, 1 granted, 2 acked
  int         m_w;
  int         m_ptr;
  logic [7:0] m_bank [4];

  function automatic void m_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_w     = 0;
    for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
  endfunction

  function automatic void m_edge(input logic [2:0] r, input logic [5:0] wa, input logic [23:0] wd);
    if (m_phase == 1) begin
      if (r[m_w]) begin
        m_bank[wa[2*m_w +: 2]] = wd[8*m_w +: 8];
        m_ptr   = (m_w + 1) % 3;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (r != 3'b000) begin
      for (int j = 2; j >= 0; j--) begin
        if (r[(m_ptr + j) % 3]) m_w = (m_ptr + j) % 3;
      end
      m_phase = 1;
    end
  endfunction

  typedef struct packed {
    logic [2:0]  req;
    logic [5:0]  waddr;
    logic [23:0] wdata;
    logic [1:0]  raddr;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic        busy;
    logic [7:0]  rdata;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [2:0] order [4];
    logic [2:0] exp_ack;
    int         nack;

    tbl[0] = '{3'b001, 6'b000010, 24'h0000A5, 2'd2, 3'b001, 3'b000, 1'b1, 8'h00};
    tbl[1] = '{3'b001, 6'b000010, 24'h0000A5, 2'd2, 3'b000, 3'b001, 1'b1, 8'hA5};
    tbl[2] = '{3'b000, 6'b000010, 24'h0000A5, 2'd2, 3'b000, 3'b000, 1'b0, 8'hA5};
    tbl[3] = '{3'b010, 6'b001110, 24'h0077A5, 2'd3, 3'b010, 3'b000, 1'b1, 8'h00};
    tbl[4] = '{3'b000, 6'b001110, 24'h0077A5, 2'd3, 3'b000, 3'b000, 1'b0, 8'h00};
    tbl[5] = '{3'b011, 6'b001110, 24'h0077A5, 2'd3, 3'b010, 3'b000, 1'b1, 8'h00};
    tbl[6] = '{3'b011, 6'b001110, 24'h0077A5, 2'd3, 3'b000, 3'b010, 1'b1, 8'h77};
    tbl[7] = '{3'b011, 6'b001110, 24'h0077A5, 2'd3, 3'b000, 3'b000, 1'b0, 8'h77};
    tbl[8] = '{3'b011, 6'b001110, 24'h0077A5, 2'd3, 3'b001, 3'b000, 1'b1, 8'h77};

    reset = 1'b1;
    req   = 3'b000;
    waddr = '0;
    wdata = '0;
    raddr = 2'd0;
    #12;
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_ack", ack, 3'b000);
    chk("reset_busy", busy, 1'b0);
    for (int a = 0; a < 4; a++) begin
      raddr = a[1:0];
      #1;
      chk("reset_bank", rdata, 8'h00);
    end
    reset = 1'b0;

    // Single write, abort with pointer kept, then a fresh round.
    for (int i = 0; i < 9; i++) begin
      req   = tbl[i].req;
      waddr = tbl[i].waddr;
      wdata = tbl[i].wdata;
      raddr = tbl[i].raddr;
      step();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ack);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdata);
    end

    // All three requesting continuously.
    req = 3'b000;
    pulse_reset();
    order[0] = 3'b001;
    order[1] = 3'b010;
    order[2] = 3'b100;
    order[3] = 3'b001;
    req   = 3'b111;
    waddr = '0;
    wdata = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_ack = (c % 3 == 2) ? order[(c - 2) / 3] : 3'b000;
      chk($sformatf("rr_ack_c%0d", c), ack, exp_ack);
    end

    // Async reset in the WRITE cycle wipes the committed value.
    req = 3'b000;
    pulse_reset();
    req   = 3'b010;
    waddr = 6'b000100;
    wdata = 24'h003C00;
    raddr = 2'd1;
    step();
    step();
    chk("midwr_ack", ack, 3'b010);
    chk("midwr_rdata", rdata, 8'h3C);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ack", ack, 3'b000);
    chk("midrst_gnt", gnt, 3'b000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_bank1", rdata, 8'h00);
    reset = 1'b0;
    req   = 3'b000;

`ifdef REGBANK_ARB_STATS_EN
    pulse_reset();
    req   = 3'b001;
    wdata = 24'h000001;
    nack  = 0;
    for (int c = 0; c < 1000 && nack < 260; c++) begin
      step();
      if (ack[0]) begin
        nack++;
        if (nack == 5) chk("stats_count5", wr_count, 8'd5);
      end
    end
    chk("stats_nack", nack, 260);
    req = 3'b000;
    step();
    chk("stats_sat", wr_count, 8'hFF);
    reset = 1'b1;
    #1;
    chk("stats_reset", wr_count, 8'h00);
    reset = 1'b0;
`endif

    // Randomized traffic with occasional async resets.
    pulse_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      req   = 3'($urandom);
      waddr = 6'($urandom);
      wdata = 24'($urandom);
      raddr = 2'($urandom);
      @(posedge clk);
      m_edge(req, waddr, wdata);
      #1;
      chk("rnd_gnt", gnt, (m_phase == 1) ? 3'(1 << m_w) : 3'b000);
      chk("rnd_ack", ack, (m_phase == 2) ? 3'(1 << m_w) : 3'b000);
      chk("rnd_busy", busy, m_phase != 0);
      chk("rnd_rdata", rdata, m_bank[raddr]);
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset();
        m_reset();
        chk("rnd_rst_busy", busy, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
